// File: rtl/decode_queue.sv
// decode_queue: circular buffer of fetched instructions (with prediction info)
// sitting between InstFetch and ROB/RS/LSB dispatch. The queue head is decoded
// combinationally and issued, one per cycle, into a registered dispatch slot.
// Optional feature macro: DECODE_RV32M_EN (adds MUL/DIV/REM decode on opcode 51).
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             jp_wrong,
   input  logic             ins_flag,
   input  logic [31:0]      ins,
   input  logic             jp_flag,
   input  logic [31:0]      jp_pc,
   output logic             stall_IF,
   input  logic             ROB_full,
   input  logic             LSB_full,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [5:0]       insty,
   output logic [31:0]      imm,
   output logic             ins_flag_ROB,
   output logic             ins_flag_RS,
   output logic             ins_flag_LSB,
   output logic [2:0]       insty_LSB,
   output logic             jp_flag_ROB,
   output logic [31:0]      jp_pc_ROB,
   output logic [PTR_W:0]   count
);

   // insty encoding; the low three bits of the load/store codes are unique
   // among memory ops so the LSB can work from insty[2:0] alone
   localparam logic [5:0] NULL6 = 6'd0;
   localparam logic [5:0] LUI   = 6'd1,  AUIPC = 6'd2,  JAL   = 6'd3,  JALR  = 6'd4;
   localparam logic [5:0] BEQ   = 6'd5,  BNE   = 6'd6,  BLT   = 6'd7,  BGE   = 6'd8;
   localparam logic [5:0] BLTU  = 6'd9,  BGEU  = 6'd10;
   localparam logic [5:0] LB    = 6'd11, LH    = 6'd12, LW    = 6'd13, LBU   = 6'd14;
   localparam logic [5:0] LHU   = 6'd15, SB    = 6'd16, SH    = 6'd17, SW    = 6'd18;
   localparam logic [5:0] ADDI  = 6'd19, SLTI  = 6'd20, SLTIU = 6'd21, XORI  = 6'd22;
   localparam logic [5:0] ORI   = 6'd23, ANDI  = 6'd24, SLLI  = 6'd25, SRLI  = 6'd26;
   localparam logic [5:0] SRAI  = 6'd27, ADD   = 6'd28, SUB   = 6'd29, SLL   = 6'd30;
   localparam logic [5:0] SLT   = 6'd31, SLTU  = 6'd32, XOR   = 6'd33, SRL   = 6'd34;
   localparam logic [5:0] SRA   = 6'd35, OR    = 6'd36, AND   = 6'd37;
`ifdef DECODE_RV32M_EN
   localparam logic [5:0] MUL   = 6'd38, MULH  = 6'd39, MULHSU = 6'd40, MULHU = 6'd41;
   localparam logic [5:0] DIV   = 6'd42, DIVU  = 6'd43, REM    = 6'd44, REMU  = 6'd45;
`endif

   localparam logic [6:0] OPC_LOAD  = 7'd3,   OPC_STORE = 7'd35, OPC_OPIMM = 7'd19;
   localparam logic [6:0] OPC_OP    = 7'd51,  OPC_BR    = 7'd99, OPC_LUI   = 7'd55;
   localparam logic [6:0] OPC_AUIPC = 7'd23,  OPC_JAL   = 7'd111, OPC_JALR = 7'd103;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   typedef struct packed {
      logic [5:0]  insty;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        to_rs;
      logic        to_lsb;
   } dec_t;

   function automatic dec_t decode_ins(input logic [31:0] ins_i);
      dec_t               d;
      logic [6:0]         opc;
      logic [2:0]         f3;
      logic               known;
      logic signed [11:0] i_imm;
      logic signed [11:0] s_imm;
      logic signed [12:0] b_imm;
      logic signed [20:0] j_imm;
      opc   = ins_i[6:0];
      f3    = ins_i[14:12];
      i_imm = ins_i[31:20];
      s_imm = {ins_i[31:25], ins_i[11:7]};
      b_imm = {ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
      j_imm = {ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
      d     = '0;
      known = 1'b1;
      d.rd  = (opc == OPC_BR || opc == OPC_STORE) ? 5'd0 : ins_i[11:7];
      d.rs1 = (opc == OPC_JAL || opc == OPC_LUI || opc == OPC_AUIPC) ? 5'd0 : ins_i[19:15];
      d.rs2 = (opc == OPC_BR || opc == OPC_STORE || opc == OPC_OP) ? ins_i[24:20] : 5'd0;
      case (opc)
         OPC_LOAD: begin
            d.to_lsb = 1'b1;
            d.imm    = 32'(i_imm);
            case (f3)
               3'd0: d.insty = LB;
               3'd1: d.insty = LH;
               3'd2: d.insty = LW;
               3'd4: d.insty = LBU;
               3'd5: d.insty = LHU;
               default: known = 1'b0;
            endcase
         end
         OPC_STORE: begin
            d.to_lsb = 1'b1;
            d.imm    = 32'(s_imm);
            case (f3)
               3'd0: d.insty = SB;
               3'd1: d.insty = SH;
               3'd2: d.insty = SW;
               default: known = 1'b0;
            endcase
         end
         OPC_OPIMM: begin
            d.to_rs = 1'b1;
            d.imm   = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins_i[24:20]} : 32'(i_imm);
            case (f3)
               3'd0: d.insty = ADDI;
               3'd1: d.insty = SLLI;
               3'd2: d.insty = SLTI;
               3'd3: d.insty = SLTIU;
               3'd4: d.insty = XORI;
               3'd5: d.insty = ins_i[30] ? SRAI : SRLI;
               3'd6: d.insty = ORI;
               default: d.insty = ANDI;
            endcase
         end
         OPC_OP: begin
            d.to_rs = 1'b1;
            if (ins_i[31:25] == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
               case (f3)
                  3'd0: d.insty = MUL;
                  3'd1: d.insty = MULH;
                  3'd2: d.insty = MULHSU;
                  3'd3: d.insty = MULHU;
                  3'd4: d.insty = DIV;
                  3'd5: d.insty = DIVU;
                  3'd6: d.insty = REM;
                  default: d.insty = REMU;
               endcase
`else
               known = 1'b0;
`endif
            end else begin
               case (f3)
                  3'd0: d.insty = ins_i[30] ? SUB : ADD;
                  3'd1: d.insty = SLL;
                  3'd2: d.insty = SLT;
                  3'd3: d.insty = SLTU;
                  3'd4: d.insty = XOR;
                  3'd5: d.insty = ins_i[30] ? SRA : SRL;
                  3'd6: d.insty = OR;
                  default: d.insty = AND;
               endcase
            end
         end
         OPC_BR: begin
            d.to_rs = 1'b1;
            d.imm   = 32'(b_imm);
            case (f3)
               3'd0: d.insty = BEQ;
               3'd1: d.insty = BNE;
               3'd4: d.insty = BLT;
               3'd5: d.insty = BGE;
               3'd6: d.insty = BLTU;
               3'd7: d.insty = BGEU;
               default: known = 1'b0;
            endcase
         end
         OPC_LUI: begin
            d.insty = LUI;
            d.imm   = {ins_i[31:12], 12'd0};
         end
         OPC_AUIPC: begin
            d.insty = AUIPC;
            d.imm   = {ins_i[31:12], 12'd0};
         end
         OPC_JAL: begin
            d.insty = JAL;
            d.imm   = 32'(j_imm);
         end
         OPC_JALR: begin
            d.to_rs = 1'b1;
            d.imm   = 32'(i_imm);
            if (f3 == 3'd0) d.insty = JALR;
            else            known   = 1'b0;
         end
         default: known = 1'b0;
      endcase
      // unrecognised encodings still go to the ROB, but to no execution unit
      if (!known) begin
         d.insty  = NULL6;
         d.to_rs  = 1'b0;
         d.to_lsb = 1'b0;
         d.imm    = '0;
      end
      return d;
   endfunction

   logic [31:0]      ins_mem_q [DEPTH];
   logic [31:0]      ins_mem_d [DEPTH];
   logic             jpf_mem_q [DEPTH];
   logic             jpf_mem_d [DEPTH];
   logic [31:0]      jpc_mem_q [DEPTH];
   logic [31:0]      jpc_mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             slot_vld_q, slot_vld_d;
   dec_t             slot_dec_q, slot_dec_d;
   logic             slot_jpf_q, slot_jpf_d;
   logic [31:0]      slot_jpc_q, slot_jpc_d;

   logic [31:0]      head_ins;
   logic             head_mem;
   logic             can_pop;
   logic             pop;
   logic             push;
   dec_t             head_dec;

   // head classification and push/pop qualification
   always_comb begin
      head_ins = ins_mem_q[head_q];
      head_mem = (head_ins[6:0] == OPC_LOAD) || (head_ins[6:0] == OPC_STORE);
      can_pop  = (count_q != '0) && !ROB_full && !(head_mem && LSB_full);
      pop      = rdy && !jp_wrong && can_pop;
      // a pop in the same cycle frees the slot, so a push at full is still legal then
      push     = rdy && !jp_wrong && ins_flag && ((count_q != FULL_CNT) || pop);
      head_dec = decode_ins(head_ins);
   end

   // queue storage write
   always_comb begin
      ins_mem_d = ins_mem_q;
      jpf_mem_d = jpf_mem_q;
      jpc_mem_d = jpc_mem_q;
      if (push) begin
         ins_mem_d[tail_q] = ins;
         jpf_mem_d[tail_q] = jp_flag;
         jpc_mem_d[tail_q] = jp_pc;
      end
   end

   // pointer and occupancy update; flush empties the queue
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (jp_wrong) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + PTR_ONE;
         if (pop)  head_d = head_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // dispatch slot: loaded on pop, decode fields zeroed on idle cycles, held when not rdy
   always_comb begin
      slot_vld_d = slot_vld_q;
      slot_dec_d = slot_dec_q;
      slot_jpf_d = slot_jpf_q;
      slot_jpc_d = slot_jpc_q;
      if (jp_wrong) begin
         slot_vld_d = 1'b0;
         slot_dec_d = '0;
         slot_jpf_d = 1'b0;
         slot_jpc_d = '0;
      end else if (rdy) begin
         if (pop) begin
            slot_vld_d = 1'b1;
            slot_dec_d = head_dec;
            slot_jpf_d = jpf_mem_q[head_q];
            slot_jpc_d = jpc_mem_q[head_q];
         end else begin
            slot_vld_d = 1'b0;
            slot_dec_d = '0;
         end
      end
   end

   // queue payload registers carry no reset; only valid entries are ever read
   always_ff @(posedge clk) begin
      ins_mem_q <= ins_mem_d;
      jpf_mem_q <= jpf_mem_d;
      jpc_mem_q <= jpc_mem_d;
   end

   // control and dispatch slot registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         slot_vld_q <= 1'b0;
         slot_dec_q <= '0;
         slot_jpf_q <= 1'b0;
         slot_jpc_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         slot_vld_q <= slot_vld_d;
         slot_dec_q <= slot_dec_d;
         slot_jpf_q <= slot_jpf_d;
         slot_jpc_q <= slot_jpc_d;
      end
   end

   assign stall_IF     = (count_q >= (FULL_CNT - CNT_ONE));
   assign count        = count_q;
   assign ins_flag_ROB = slot_vld_q;
   assign insty        = slot_dec_q.insty;
   assign insty_LSB    = slot_dec_q.insty[2:0];
   assign rd           = slot_dec_q.rd;
   assign rs1          = slot_dec_q.rs1;
   assign rs2          = slot_dec_q.rs2;
   assign imm          = slot_dec_q.imm;
   assign ins_flag_RS  = slot_dec_q.to_rs;
   assign ins_flag_LSB = slot_dec_q.to_lsb;
   assign jp_flag_ROB  = slot_jpf_q;
   assign jp_pc_ROB    = slot_jpc_q;

endmodule
